// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: FSM state encoding and SPI mode-0 constants.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } spi_slv_state_t;

  // Mode 0: SCLK idles low, data sampled on the leading (rising) edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  // Synchronizer reset image, ordered {SCLK, SS_N, MOSI}.
  localparam logic [2:0] SPI_SYNC_RST = {SPI_CPOL, 1'b1, 1'b0};

endpackage

// File: rtl/spi_sync.sv
// Multi-bit flop-chain synchronizer with a parameterized reset image.
module spi_sync #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             sresetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [STAGES];

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= RST_VAL;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/spi_slv.sv
// SPI mode-0 slave with one-word TX buffer and right-aligned RX word.
// Optional macro SPI_SLV_UNDERRUN_EN enables the tx_underrun pulse.
//
// state  | meaning
// IDLE   | waiting for SS_N falling edge
// ACTIVE | frame in progress, shifting on SCLK edges
// DONE   | frame ended, publish received word (one cycle)
module spi_slv
  import spi_pkg::*;
#(
  parameter int SPI_MAXLEN  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        sresetn,
  input  logic                        SCLK,
  input  logic                        SS_N,
  input  logic                        MOSI,
  output logic                        MISO,
  input  logic [SPI_MAXLEN-1:0]       tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [SPI_MAXLEN-1:0]       rx_data,
  output logic [$clog2(SPI_MAXLEN):0] rx_len,
  output logic                        rx_valid,
  output logic                        busy,
  output logic                        tx_underrun
);

  localparam int            LW     = $clog2(SPI_MAXLEN) + 1;
  localparam logic [LW-1:0] MAXCNT = LW'(SPI_MAXLEN);

  logic [2:0] sync_q;
  logic       sclk_s, ss_n_s, mosi_s;
  logic       sclk_d, ss_n_d;
  logic       ss_fall, ss_rise, lead_edge, trail_edge;

  spi_sync #(
    .WIDTH  (3),
    .STAGES (SYNC_STAGES),
    .RST_VAL(SPI_SYNC_RST)
  ) u_sync (
    .clk    (clk),
    .sresetn(sresetn),
    .d      ({SCLK, SS_N, MOSI}),
    .q      (sync_q)
  );

  assign {sclk_s, ss_n_s, mosi_s} = sync_q;

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      sclk_d <= SPI_CPOL;
      ss_n_d <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      ss_n_d <= ss_n_s;
    end
  end

  assign ss_fall    = ss_n_d & ~ss_n_s;
  assign ss_rise    = ~ss_n_d & ss_n_s;
  assign lead_edge  = (sclk_s ^ sclk_d) & (sclk_s ^ SPI_CPOL);
  assign trail_edge = (sclk_s ^ sclk_d) & ~(sclk_s ^ SPI_CPOL);

  // The synchronizer comes out of reset showing SS_N high; if the pin is
  // actually low, that first transition is not a real frame start. Only arm
  // once the chain has flushed and SS_N has been seen high.
  logic [SYNC_STAGES:0] flush_sr;
  logic                 armed;

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      flush_sr <= '0;
      armed    <= 1'b0;
    end else begin
      flush_sr <= {flush_sr[SYNC_STAGES-1:0], 1'b1};
      armed    <= armed | (flush_sr[SYNC_STAGES] & ss_n_s);
    end
  end

  spi_slv_state_t state, state_nxt;
  logic           start, in_frame, done;

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall && armed) state_nxt = ACTIVE;
      ACTIVE:  if (ss_rise)          state_nxt = DONE;
      DONE:                          state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start    = 1'b0;
    in_frame = 1'b0;
    done     = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE:   start = ss_fall && armed;
      ACTIVE: begin
        busy     = 1'b1;
        in_frame = !ss_rise;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  logic                  buf_full;
  logic [SPI_MAXLEN-1:0] buf_data;
  logic [SPI_MAXLEN-1:0] tx_sr;
  logic [SPI_MAXLEN-1:0] rx_sr;
  logic [LW-1:0]         bit_cnt;

  assign tx_ready = !buf_full;

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      buf_full <= 1'b0;
      buf_data <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
    end else begin
      if (start) begin
        tx_sr   <= buf_full ? buf_data : '0;
        rx_sr   <= '0;
        bit_cnt <= '0;
      end else if (in_frame) begin
        if (trail_edge) tx_sr <= {tx_sr[SPI_MAXLEN-2:0], 1'b0};
        if (lead_edge && (bit_cnt < MAXCNT)) begin
          rx_sr   <= {rx_sr[SPI_MAXLEN-2:0], mosi_s};
          bit_cnt <= bit_cnt + LW'(1);
        end
      end
      // A word accepted in the start cycle itself belongs to the next frame.
      if (start) buf_full <= 1'b0;
      if (tx_valid && tx_ready) begin
        buf_full <= 1'b1;
        buf_data <= tx_data;
      end
    end
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      rx_data  <= '0;
      rx_len   <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= done && (bit_cnt != '0);
      if (done && (bit_cnt != '0)) begin
        rx_data <= rx_sr;
        rx_len  <= bit_cnt;
      end
    end
  end

  assign MISO = (state == ACTIVE) && !ss_n_s && tx_sr[SPI_MAXLEN-1];

`ifdef SPI_SLV_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) underrun_q <= 1'b0;
    else          underrun_q <= start && !buf_full;
  end

  assign tx_underrun = underrun_q;
`else
  assign tx_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slv.sv
// Directed bench for spi_slv: table of mode-0 frames plus reset-mid-frame sequence.
module tb_spi_slv;

  logic        clk = 1'b0;
  logic        sresetn;
  logic        SCLK, SS_N, MOSI;
  logic        MISO;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic [5:0]  rx_len;
  logic        rx_valid;
  logic        busy;
  logic        tx_underrun;

`ifdef SPI_SLV_UNDERRUN_EN
  localparam int UR = 1;
`else
  localparam int UR = 0;
`endif

  spi_slv dut (
    .clk        (clk),
    .sresetn    (sresetn),
    .SCLK       (SCLK),
    .SS_N       (SS_N),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_len     (rx_len),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int ur_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1)    valid_cnt <= valid_cnt + 1;
    if (tx_underrun === 1'b1) ur_cnt    <= ur_cnt + 1;
  end

  // tx_mode: 0 = no load, 1 = load before SS_N falls, 2 = load during the frame
  typedef struct {
    int          tx_mode;
    logic [31:0] tx_word;
    logic [63:0] mosi;
    int          nbits;
    logic [63:0] exp_miso;
    logic [31:0] exp_rx;
    int          exp_len;
    int          exp_valid;
    int          exp_ur;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] w, input string nm);
    @(negedge clk);
    check({nm, "_ready_before"}, 64'(tx_ready), 64'd1);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check({nm, "_ready_after"}, 64'(tx_ready), 64'd0);
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    logic [63:0] cap;
    int v0, u0;
    cap = '0;
    @(negedge clk);
    if (v.tx_mode == 1) load_word(v.tx_word, nm);
    v0 = valid_cnt;
    u0 = ur_cnt;
    SS_N = 1'b0;
    #80;
    if (v.tx_mode == 2) load_word(v.tx_word, nm);
    for (int i = 0; i < v.nbits; i++) begin
      MOSI = v.mosi[v.nbits-1-i];
      #80;
      cap  = {cap[62:0], MISO};
      SCLK = 1'b1;
      #80;
      SCLK = 1'b0;
    end
    #80;
    SS_N = 1'b1;
    MOSI = 1'b0;
    repeat (12) @(negedge clk);
    check({nm, "_valid_cnt"}, 64'(valid_cnt - v0), 64'(v.exp_valid));
    if (v.exp_valid != 0) begin
      check({nm, "_rx_data"}, 64'(rx_data), 64'(v.exp_rx));
      check({nm, "_rx_len"},  64'(rx_len),  64'(v.exp_len));
    end
    if (v.nbits > 0) check({nm, "_miso"}, cap, v.exp_miso);
    check({nm, "_underrun"}, 64'(ur_cnt - u0), 64'(v.exp_ur));
    check({nm, "_busy"}, 64'(busy), 64'd0);
    check({nm, "_tx_ready"}, 64'(tx_ready), (v.tx_mode == 2) ? 64'd0 : 64'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    vec_t post;

    vecs[0] = '{1, 32'hA5A5_0F0F, 64'h1234_5678,    32, 64'hA5A5_0F0F,    32'h1234_5678, 32, 1, 0};
    vecs[1] = '{1, 32'h5A00_0000, 64'hC3,           8,  64'h5A,           32'h0000_00C3, 8,  1, 0};
    vecs[2] = '{2, 32'h3C3C_3C3C, 64'h0F0F,         16, 64'h0,            32'h0000_0F0F, 16, 1, UR};
    vecs[3] = '{0, 32'h0,         64'h81,           8,  64'h3C,           32'h0000_0081, 8,  1, 0};
    vecs[4] = '{1, 32'h8000_0001, 64'hDE_ADBE_EF55, 40, 64'h80_0000_0100, 32'hDEAD_BEEF, 32, 1, 0};
    vecs[5] = '{1, 32'h1357_9BDF, 64'h0,            0,  64'h0,            32'h0,         0,  0, 0};
    vecs[6] = '{1, 32'hFFFF_FFFF, 64'h1,            1,  64'h1,            32'h0000_0001, 1,  1, 0};

    sresetn  = 1'b0;
    SCLK     = 1'b0;
    SS_N     = 1'b1;
    MOSI     = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    #3;
    check("rst_miso",     64'(MISO),        64'd0);
    check("rst_tx_ready", 64'(tx_ready),    64'd1);
    check("rst_rx_valid", 64'(rx_valid),    64'd0);
    check("rst_underrun", 64'(tx_underrun), 64'd0);
    check("rst_busy",     64'(busy),        64'd0);
    check("rst_rx_data",  64'(rx_data),     64'd0);
    check("rst_rx_len",   64'(rx_len),      64'd0);
    repeat (3) @(negedge clk);
    sresetn = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 7; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a frame, SS_N still low across release.
    load_word(32'hFFFF_FFFF, "rstmid_load");
    SS_N = 1'b0;
    #80;
    for (int i = 0; i < 10; i++) begin
      MOSI = i[0];
      #80;
      SCLK = 1'b1;
      #80;
      SCLK = 1'b0;
    end
    #80;
    check("rstmid_miso_before", 64'(MISO), 64'd1);
    v0 = valid_cnt;
    sresetn = 1'b0;
    #3;
    check("rstmid_miso",     64'(MISO),     64'd0);
    check("rstmid_busy",     64'(busy),     64'd0);
    check("rstmid_tx_ready", 64'(tx_ready), 64'd1);
    check("rstmid_rx_data",  64'(rx_data),  64'd0);
    check("rstmid_rx_len",   64'(rx_len),   64'd0);
    repeat (3) @(negedge clk);
    sresetn = 1'b1;
    repeat (2) begin
      #80;
      SCLK = 1'b1;
      #80;
      SCLK = 1'b0;
    end
    check("rstmid_no_restart", 64'(busy), 64'd0);
    check("rstmid_miso_after", 64'(MISO), 64'd0);
    SS_N = 1'b1;
    MOSI = 1'b0;
    repeat (12) @(negedge clk);
    check("rstmid_no_valid", 64'(valid_cnt - v0), 64'd0);

    post = '{1, 32'hCAFE_F00D, 64'h89AB_CDEF, 32, 64'hCAFE_F00D, 32'h89AB_CDEF, 32, 1, 0};
    run_frame(post, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slv.md
SPI_SLV -- requirements
Module: spi_slv

Interface
REQ-001 SHALL have parameter SPI_MAXLEN, default 32, maximum frame length in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on SCLK/SS_N/MOSI.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port sresetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SCLK  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0).
REQ-006 SHALL have port SS_N  input  1  slave select, active-low.
REQ-007 SHALL have port MOSI  input  1  serial data from master.
REQ-008 SHALL have port MISO  output  1  serial data to master, MSB first.
REQ-009 SHALL have port tx_data  input  SPI_MAXLEN  next response word.
REQ-010 SHALL have port tx_valid  input  1  tx_data valid.
REQ-011 SHALL have port tx_ready  output  1  buffer empty; word accepted when tx_valid&&tx_ready.
REQ-012 SHALL have port rx_data  output  SPI_MAXLEN  received word, right-aligned.
REQ-013 SHALL have port rx_len  output  $clog2(SPI_MAXLEN)+1  bits received in last frame.
REQ-014 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data/rx_len valid.
REQ-015 SHALL have port busy  output  1  frame in progress.
REQ-016 SHALL have port tx_underrun  output  1  one-cycle pulse, frame started with empty buffer.

Function
REQ-017 SHALL pass SCLK, SS_N, MOSI through SYNC_STAGES flops on clk; all logic uses synchronized copies; clk >= 8x SCLK frequency.
REQ-018 SHALL detect SCLK rising/falling edges and SS_N falling/rising edges by comparing the synchronized value with a one-cycle-delayed copy.
REQ-019 SHALL implement states IDLE, ACTIVE, DONE; IDLE->ACTIVE on SS_N falling edge; ACTIVE->DONE on SS_N rising edge; DONE->IDLE after one cycle.
REQ-020 SHALL, on IDLE->ACTIVE, load the TX shift register from the one-word buffer (buffer then empty, tx_ready=1) and clear the bit counter and RX shift register.
REQ-021 SHALL, if the buffer is empty at IDLE->ACTIVE, load all zeros and assert tx_underrun for one cycle.
REQ-022 SHALL drive MISO from TX shift register MSB; first bit valid from entry to ACTIVE, shift left by one on each SCLK falling edge.
REQ-023 SHALL sample MOSI on each SCLK rising edge, shifting into RX register LSB, and increment bit counter, saturating at SPI_MAXLEN.
REQ-024 SHALL ignore rising edges beyond SPI_MAXLEN (no shift, counter held).
REQ-025 SHALL, in DONE, latch rx_data and rx_len and pulse rx_valid for one cycle only if bit counter > 0; frames of zero bits produce no rx_valid.
REQ-026 SHALL accept tx_data whenever tx_ready=1, including during ACTIVE; an accepted word is used in the next frame.
REQ-027 SHALL assert busy in ACTIVE and DONE; SCLK edges outside ACTIVE have no effect.
REQ-028 SHALL drive MISO=0 while SS_N synchronized is high.
REQ-029 SHALL treat simultaneous SCLK edge and SS_N rising edge as end of frame; the SCLK edge is discarded.

Reset
REQ-030 SHALL, on sresetn low, force state IDLE, MISO=0, tx_ready=1, rx_valid=0, tx_underrun=0, busy=0, rx_data=0, rx_len=0, buffer empty, synchronizers to SCLK=0/SS_N=1/MOSI=0.
REQ-031 SHALL, on reset mid-frame, abandon the frame with no rx_valid; after release, wait for a new SS_N falling edge.

Configuration
REQ-032 SHALL, with SPI_SLV_UNDERRUN_EN defined, implement REQ-021 tx_underrun pulse; without it, tx_underrun tied 0 while zero-fill still applies.

Structure
REQ-033 SHALL place state enum spi_slv_state_t and mode-0 constants in shared package spi_pkg.
REQ-034 SHALL instantiate sub-module spi_sync (parameterized multi-bit flop synchronizer) for input synchronization.

Verification
REQ-035 SHALL check: tx_data=0xA5A5_0F0F loaded, 32-bit frame MOSI=0x1234_5678 -> MISO stream 0xA5A50F0F, rx_data=0x12345678, rx_len=32, one rx_valid.
REQ-036 SHALL check: 8-bit frame MOSI=0xC3 -> rx_data=0x000000C3, rx_len=8.
REQ-037 SHALL check: no tx_valid before frame -> MISO all 0, tx_underrun one pulse (macro on), absent (macro off).
REQ-038 SHALL check: 40 SCLK cycles in one frame -> rx_len=32, first 32 bits retained.
REQ-039 SHALL check: sresetn low after 10 bits -> no rx_valid, MISO=0, next full frame correct.
REQ-040 SHALL check: SS_N low then high with no SCLK -> no rx_valid, buffer consumed, tx_ready=1.
